// File: rtl/sort1_axil_sort_core.sv
// AXI4-Lite slave holding four 32-bit input words, sorting them with a
// 4-phase odd-even transposition network on command, and exposing the
// sorted words plus status as read-only registers.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET      clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B* write address, data and response channels
//   S_AXI_AR* / S_AXI_R*           read address and data channels
//
// Register map (byte address, decode on addr[5:2]):
//   0x00-0x0C IN0..IN3 (RW, byte strobes)   0x10 CTRL {DESC, START}
//   0x14 STATUS {DONE, BUSY} (RO)           0x18 SWAP_CNT[2:0] (RO)
//   0x20-0x2C OUT0..OUT3 (RO)               others read 0, writes ignored
module sort1_axil_sort_core #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = DW / 8;

    localparam logic [3:0] IDX_CTRL   = 4'h4;
    localparam logic [3:0] IDX_STATUS = 4'h5;
    localparam logic [3:0] IDX_SWAP   = 4'h6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SORT = 1'b1
    } state_e;

    // AXI handshake registers
    logic          awready_q;
    logic          bvalid_q;
    logic          arready_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

    // Register file and sort datapath
    logic [DW-1:0] in_q  [4];
    logic [DW-1:0] out_q [4];
    logic [DW-1:0] w_q   [4];
    logic [DW-1:0] w_d   [4];
    logic          desc_q;
    logic          order_q;
    logic          busy_q;
    logic          done_q;
    logic [2:0]    swap_cnt_q;
    logic [1:0]    swap_inc_d;
    logic [1:0]    phase_q;
    state_e        state_q;

    logic          wr_fire_c;
    logic          rd_fire_c;
    logic          start_c;
    logic [3:0]    wr_idx_c;
    logic [3:0]    rd_idx_c;
    logic [DW-1:0] rd_data_c;

    logic unused_c;
    assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;

    assign wr_fire_c = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_fire_c = arready_q && S_AXI_ARVALID;
    assign wr_idx_c  = S_AXI_AWADDR[5:2];
    assign rd_idx_c  = S_AXI_ARADDR[5:2];
    // START only launches from IDLE; byte 0 must be strobed
    assign start_c   = wr_fire_c && (wr_idx_c == IDX_CTRL) && S_AXI_WSTRB[0] &&
                       S_AXI_WDATA[0] && (state_q == ST_IDLE);

    // Byte-enable merge for RW registers
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < int'(SW); b++) begin
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    // Unsigned compare; equal values never swap in either order
    function automatic logic need_swap(input logic [DW-1:0] lo,
                                       input logic [DW-1:0] hi,
                                       input logic          desc);
        return desc ? (lo < hi) : (lo > hi);
    endfunction

    // One transposition phase: even phases pair (0,1),(2,3); odd phases pair (1,2)
    always_comb begin
        w_d        = w_q;
        swap_inc_d = 2'd0;
        if (!phase_q[0]) begin
            if (need_swap(w_q[0], w_q[1], order_q)) begin
                w_d[0]     = w_q[1];
                w_d[1]     = w_q[0];
                swap_inc_d = swap_inc_d + 2'd1;
            end
            if (need_swap(w_q[2], w_q[3], order_q)) begin
                w_d[2]     = w_q[3];
                w_d[3]     = w_q[2];
                swap_inc_d = swap_inc_d + 2'd1;
            end
        end else if (need_swap(w_q[1], w_q[2], order_q)) begin
            w_d[1]     = w_q[2];
            w_d[2]     = w_q[1];
            swap_inc_d = 2'd1;
        end
    end

    // Read data mux
    always_comb begin
        rd_data_c = '0;
        case (rd_idx_c)
            4'h0, 4'h1, 4'h2, 4'h3: rd_data_c = in_q[rd_idx_c[1:0]];
            IDX_CTRL:               rd_data_c = DW'({desc_q, 1'b0});
            IDX_STATUS:             rd_data_c = DW'({done_q, busy_q});
            IDX_SWAP:               rd_data_c = DW'(swap_cnt_q);
            4'h8, 4'h9, 4'hA, 4'hB: rd_data_c = out_q[rd_idx_c[1:0]];
            default:                rd_data_c = '0;
        endcase
    end

    // AXI channels, register file and sort FSM
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            desc_q     <= 1'b0;
            order_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            swap_cnt_q <= 3'd0;
            phase_q    <= 2'd0;
            state_q    <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                in_q[i]  <= '0;
                out_q[i] <= '0;
                w_q[i]   <= '0;
            end
        end else begin
            // Write address/data accepted together, one outstanding response
            awready_q <= !awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
            if (wr_fire_c) begin
                bvalid_q <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end

            // Read data captured at the address handshake (pre-update values)
            arready_q <= !arready_q && S_AXI_ARVALID && !rvalid_q;
            if (rd_fire_c) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data_c;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end

            if (wr_fire_c) begin
                if (wr_idx_c[3:2] == 2'b00) begin
                    in_q[wr_idx_c[1:0]] <= merge_bytes(in_q[wr_idx_c[1:0]], S_AXI_WDATA, S_AXI_WSTRB);
                end else if (wr_idx_c == IDX_CTRL && S_AXI_WSTRB[0]) begin
                    desc_q <= S_AXI_WDATA[1];
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        w_q        <= in_q;
                        order_q    <= S_AXI_WDATA[1];
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        swap_cnt_q <= 3'd0;
                        phase_q    <= 2'd0;
                        state_q    <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    w_q        <= w_d;
                    swap_cnt_q <= swap_cnt_q + 3'(swap_inc_d);
                    phase_q    <= phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        out_q   <= w_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort1_axil_sort_core.sv
// Scoreboard bench for sort1_axil_sort_core: stimulus pushes expected read
// data / write responses; a negedge monitor pops and compares on handshakes.
module tb_sort1_axil_sort_core;

    localparam logic [5:0] A_CTRL   = 6'h10;
    localparam logic [5:0] A_STATUS = 6'h14;
    localparam logic [5:0] A_SWAP   = 6'h18;
    localparam logic [5:0] A_OUT0   = 6'h20;

    typedef struct {
        logic [31:0] data;
        string       name;
    } rexp_t;

    logic        clk = 1'b0;
    logic        areset;
    logic [5:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [5:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    rexp_t       exp_r[$];
    logic [1:0]  exp_b[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    sort1_axil_sort_core #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (areset),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp_v);
        end
    endtask

    task automatic note_fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    // Called just after a posedge; returns 1ns after the handshake edge
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) note_fail("aw_timeout");
        else exp_b.push_back(2'b00);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] e, input string nm);
        int n = 0;
        rexp_t x;
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (!arready) note_fail({nm, "_ar_timeout"});
        else begin x.data = e; x.name = nm; exp_r.push_back(x); end
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 100) begin @(negedge clk); n++; end
        if (exp_r.size() != 0 || exp_b.size() != 0) note_fail("drain_timeout");
        @(posedge clk); #1;
    endtask

    // Monitor: compares every completed R and B beat against the scoreboard
    always @(negedge clk) begin
        if (!areset && rvalid && rready) begin
            if (exp_r.size() == 0) note_fail("r_unexpected");
            else begin
                rexp_t x;
                x = exp_r.pop_front();
                chk(x.name, rdata, x.data);
                chk({x.name, "_rresp"}, 32'(rresp), 32'(0));
            end
        end
        if (!areset && bvalid && bready) begin
            if (exp_b.size() == 0) note_fail("b_unexpected");
            else chk("bresp", 32'(bresp), 32'(exp_b.pop_front()));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;

        // 1: reset state
        chk("rst_awready", 32'(awready), 0);
        chk("rst_arready", 32'(arready), 0);
        repeat (3) @(negedge clk);
        chk("idle_bvalid", 32'(bvalid), 0);
        chk("idle_rvalid", 32'(rvalid), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) axi_read(6'(4 * i), 32'h0, $sformatf("rst_rd_%02h", 4 * i));

        // 2: write/read-back, byte strobes, RO and undecoded writes
        for (int i = 0; i < 4; i++) axi_write(6'(4 * i), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) axi_read(6'(4 * i), 32'(i + 1), $sformatf("in%0d_rb", i));
        axi_write(6'h00, 32'hAABBCCDD, 4'b0101);
        axi_read(6'h00, 32'h00BB00DD, "in0_strb");
        axi_write(A_STATUS, 32'hFFFFFFFF, 4'hF);
        axi_write(6'h1C, 32'hDEADBEEF, 4'hF);
        axi_write(6'h30, 32'hDEADBEEF, 4'hF);
        axi_read(A_STATUS, 32'h0, "status_ro");
        axi_read(6'h1C, 32'h0, "undec_1c");
        axi_read(6'h30, 32'h0, "undec_30");

        // 3: ascending 4,3,2,1; STATUS busy at T+4, then done
        for (int i = 0; i < 4; i++) axi_write(6'(4 * i), 32'(4 - i), 4'hF);
        drain();
        axi_write(A_CTRL, 32'h1, 4'hF);
        repeat (2) @(posedge clk); #1;
        axi_read(A_STATUS, 32'h1, "status_busy_t4");
        axi_read(A_STATUS, 32'h2, "status_done");
        for (int i = 0; i < 4; i++) axi_read(6'(A_OUT0 + 6'(4 * i)), 32'(i + 1), $sformatf("asc_out%0d", i));
        axi_read(A_SWAP, 32'd6, "asc_swap");
        axi_read(A_CTRL, 32'h0, "ctrl_asc");

        // 4: descending unsigned; DONE must be visible at T+5
        axi_write(6'h00, 32'h00000010, 4'hF);
        axi_write(6'h04, 32'hFFFFFFFF, 4'hF);
        axi_write(6'h08, 32'h00000000, 4'hF);
        axi_write(6'h0C, 32'h00000007, 4'hF);
        drain();
        axi_write(A_CTRL, 32'h3, 4'hF);
        repeat (3) @(posedge clk); #1;
        axi_read(A_STATUS, 32'h2, "status_done_t5");
        axi_read(A_OUT0 + 6'h0, 32'hFFFFFFFF, "desc_out0");
        axi_read(A_OUT0 + 6'h4, 32'h00000010, "desc_out1");
        axi_read(A_OUT0 + 6'h8, 32'h00000007, "desc_out2");
        axi_read(A_OUT0 + 6'hC, 32'h00000000, "desc_out3");
        axi_read(A_SWAP, 32'd2, "desc_swap");
        axi_read(A_CTRL, 32'h2, "ctrl_desc");

        // 5a: second START (with DESC=1) while busy is ignored, DESC still updates
        axi_write(6'h00, 32'd5, 4'hF);
        axi_write(6'h04, 32'd1, 4'hF);
        axi_write(6'h08, 32'd4, 4'hF);
        axi_write(6'h0C, 32'd2, 4'hF);
        axi_write(A_CTRL, 32'h1, 4'hF);
        axi_write(A_CTRL, 32'h3, 4'hF);
        repeat (6) @(posedge clk); #1;
        axi_read(A_STATUS, 32'h2, "dbl_status");
        axi_read(A_OUT0 + 6'h0, 32'd1, "dbl_out0");
        axi_read(A_OUT0 + 6'h4, 32'd2, "dbl_out1");
        axi_read(A_OUT0 + 6'h8, 32'd4, "dbl_out2");
        axi_read(A_OUT0 + 6'hC, 32'd5, "dbl_out3");
        axi_read(A_SWAP, 32'd4, "dbl_swap");
        axi_read(A_CTRL, 32'h2, "dbl_ctrl");

        // 5b: IN0 rewritten during a descending sort does not disturb it
        axi_write(A_CTRL, 32'h3, 4'hF);
        axi_write(6'h00, 32'h55, 4'hF);
        repeat (6) @(posedge clk); #1;
        axi_read(A_OUT0 + 6'h0, 32'd5, "inbusy_out0");
        axi_read(A_OUT0 + 6'h4, 32'd4, "inbusy_out1");
        axi_read(A_OUT0 + 6'h8, 32'd2, "inbusy_out2");
        axi_read(A_OUT0 + 6'hC, 32'd1, "inbusy_out3");
        axi_read(A_SWAP, 32'd2, "inbusy_swap");
        axi_read(6'h00, 32'h55, "inbusy_in0");

        // 6a: BREADY low holds BVALID and blocks a second write
        drain();
        bready = 1'b0;
        axi_write(6'h04, 32'h11, 4'hF);
        awaddr = 6'h08; wdata = 32'h22; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(bvalid), 1);
            chk("aw_blocked", 32'(awready), 0);
            chk("w_blocked", 32'(wready), 0);
        end
        @(posedge clk); #1 bready = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!awready && n < 50) begin @(negedge clk); n++; end
            if (!awready) note_fail("aw2_timeout");
            else exp_b.push_back(2'b00);
            @(posedge clk); #1;
            awvalid = 1'b0; wvalid = 1'b0;
        end
        axi_read(6'h04, 32'h11, "bp_in1");
        axi_read(6'h08, 32'h22, "bp_in2");

        // 6b: reset at T+2 of a sort aborts it and clears everything
        drain();
        axi_write(A_CTRL, 32'h1, 4'hF);
        @(posedge clk); #1 areset = 1'b1;
        @(posedge clk); #1 areset = 1'b0;
        chk("mid_rst_bvalid", 32'(bvalid), 0);
        chk("mid_rst_rvalid", 32'(rvalid), 0);
        axi_read(A_STATUS, 32'h0, "mid_rst_status");
        for (int i = 0; i < 4; i++) axi_read(6'(A_OUT0 + 6'(4 * i)), 32'h0, $sformatf("mid_rst_out%0d", i));
        axi_read(A_SWAP, 32'h0, "mid_rst_swap");
        axi_read(6'h00, 32'h0, "mid_rst_in0");
        repeat (6) @(posedge clk); #1;
        axi_read(A_STATUS, 32'h0, "mid_rst_status_late");

        // FSM back in IDLE: a fresh sort runs normally
        for (int i = 0; i < 4; i++) axi_write(6'(4 * i), 32'(9 - i), 4'hF);
        axi_write(A_CTRL, 32'h1, 4'hF);
        repeat (6) @(posedge clk); #1;
        axi_read(A_STATUS, 32'h2, "post_rst_status");
        for (int i = 0; i < 4; i++) axi_read(6'(A_OUT0 + 6'(4 * i)), 32'(6 + i), $sformatf("post_rst_out%0d", i));
        axi_read(A_SWAP, 32'd6, "post_rst_swap");

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sort1_axil_sort_core.md
Name: sort1_axil_sort_core

Overview:
- AXI4-Lite slave that sits directly downstream of the sort1 master agent.
- Holds four 32-bit input words and runs an odd-even transposition sort on them when commanded.
- Exposes the sorted result and status as read-only registers.
- Input registers read back exactly what was written, so the existing write/read-back regression on 0x00–0x0C still passes.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6: byte address width; decode uses addr[5:2].

Ports:
- S_AXI_ACLK  in  1  single clock; everything in this block is synchronous to it.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  6  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1;  S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32;  S_AXI_WSTRB  in  4  byte enables, honoured on RW registers.
- S_AXI_WVALID  in  1;  S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2;  S_AXI_BVALID  out  1;  S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  6;  S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1;  S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32;  S_AXI_RRESP  out  2;  S_AXI_RVALID  out  1;  S_AXI_RREADY  in  1.

Behaviour:

Reset:
- On a clock edge with S_AXI_ARESET=1, all of the following go to 0: ready/valid outputs, RDATA, BRESP, RRESP, IN0–3, OUT0–3, CTRL.DESC, BUSY, DONE, SWAP_CNT, and the FSM state (IDLE).
- A reset in the middle of a sort aborts it; OUT registers are zeroed.

Register map (undecoded addresses read 0, writes ignored, response OKAY):
- 0x00–0x0C IN0..IN3: RW.
- 0x10 CTRL:
  - bit0 START: write-1 pulse, reads 0.
  - bit1 DESC: RW sort order.
- 0x14 STATUS: RO. bit0 BUSY, bit1 DONE.
- 0x18 SWAP_CNT: RO [2:0], number of swaps in the last completed sort.
- 0x20–0x2C OUT0..OUT3: RO.

Write channel:
- AWREADY and WREADY pulse high together for one cycle when AWVALID, WVALID and !BVALID are all 1.
- The register is updated on that same edge.
- BVALID rises the next cycle and holds until BREADY.
- No new write is accepted while BVALID=1.
- BRESP is always 00.

Read channel:
- ARREADY pulses for one cycle when ARVALID and !RVALID.
- RDATA is registered and RVALID rises the next cycle; both hold until RREADY.
- RRESP is always 00.
- Reads and writes are independent and may complete in the same cycle.
- A read of STATUS in the same cycle as a START write returns the pre-start value.

Sort FSM, states IDLE and SORT(phase 0..3):
- IDLE → SORT0 on an accepted CTRL write with WDATA[0]=1 (byte 0 strobed).
  - Same edge: W0..W3 ← IN0..IN3, BUSY←1, DONE←0, SWAP_CNT←0, order latched from the DESC value being written.
- Phases 0 and 2 compare-swap pairs (W0,W1) and (W2,W3); phases 1 and 3 compare-swap (W1,W2).
  - Comparison is unsigned.
  - Ascending swaps when Wlow > Whigh; descending swaps when Wlow < Whigh. Equal values never swap.
  - SWAP_CNT increments by the number of swaps in the phase (0–2); maximum total is 6.
- On the phase-3 edge: OUT0..3 ← final W values, BUSY←0, DONE←1, return to IDLE.
- Timing: START accepted at edge T → BUSY=1 during cycles T+1..T+4; OUT and DONE are valid from T+5. Latency is fixed at 4 cycles.
- START while BUSY is ignored (the DESC bit still updates CTRL).
- IN writes during BUSY update IN but do not affect the sort in progress.
- DONE stays set until the next accepted START.

Test Plan:
1. Reset, then read 0x00–0x2C → all 0; BVALID/RVALID stay 0 until a request arrives.
2. Write IN0..3 = 1,2,3,4 and read back → 1,2,3,4, RRESP=00.
3. IN = 4,3,2,1; write CTRL=0x1; poll STATUS → 0x1 for 4 cycles, then 0x2; OUT = 1,2,3,4; SWAP_CNT=6.
4. IN = 0x10, 0xFFFFFFFF, 0, 0x7; write CTRL=0x3 → OUT = 0xFFFFFFFF, 0x10, 0x7, 0 (unsigned, descending).
5. START, then immediately START again and rewrite IN0=0x55 while BUSY → second START ignored; OUT reflects the original inputs.
6. Hold BREADY=0 for 10 cycles → BVALID held and a second AW/W is not accepted. Assert reset at T+2 of a sort → STATUS=0, OUT=0, FSM in IDLE.
